// File: rtl/flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_pkg
// Brief    : Shared widths, request record and byte-lane masking helper for
//            the flash responder.
// Revision : 1.0
// ============================================================================
package flash_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
    } req_t;

    // Disabled byte lanes are forced to zero rather than passed through.
    function automatic logic [DATA_W-1:0] lane_mask(
        input logic [DATA_W-1:0] data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < BE_W; i++) begin
            r[i*8 +: 8] = be[i] ? data[i*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : req_fifo
// Brief    : Synchronous first-word-fall-through FIFO of read requests.
// Revision : 1.0
// ============================================================================
module req_fifo
    import flash_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  req_t i_data,
    input  logic i_pop,
    output req_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    req_t               r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wptr;
    logic [c_PTR_W:0]   r_rptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_PTR_W-1:0]] <= i_data;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_data  = r_mem[r_rptr[c_PTR_W-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                     (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : flash_responder
// Brief    : Avalon-MM read responder with wait-state insertion, request
//            buffering and a two-stage return pipeline to a backing memory.
// Revision : 1.0
// ============================================================================
module flash_responder
    import flash_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [BE_W-1:0]   byteenable,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rddata,
    output logic [15:0]       served_count,
    input  logic              issue_hold
);

    localparam int                 c_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT  = c_CNT_W'(WAIT_CYCLES);

    logic [c_CNT_W-1:0] r_stall_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_v1;
    logic [BE_W-1:0]    r_be1;
    logic               r_v2;
    logic [DATA_W-1:0]  r_rdata;
    logic [15:0]        r_served;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_issue;
    req_t               w_head;
    req_t               w_req_in;

    assign waitrequest = reset | w_full | (read & (r_stall_cnt != c_WAIT));
    assign w_accept    = read & ~waitrequest;
    assign w_req_in    = '{address: address, byteenable: byteenable};

    req_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_accept),
        .i_data  (w_req_in),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Counter holds while the FIFO is full so the wait phase is not replayed.
    always_ff @(posedge clk) begin
        if (reset || !read || w_accept) begin
            r_stall_cnt <= '0;
        end else if (!w_full && r_stall_cnt != c_WAIT) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_issue  = ~w_empty & ~issue_hold & ~reset;
    assign mem_en   = w_issue;
    assign mem_addr = w_issue ? w_head.address : r_mem_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_v1       <= 1'b0;
            r_be1      <= '0;
            r_v2       <= 1'b0;
            r_rdata    <= '0;
            r_served   <= '0;
        end else begin
            r_v1 <= w_issue;
            if (w_issue) begin
                r_mem_addr <= w_head.address;
                r_be1      <= w_head.byteenable;
            end
            r_v2 <= r_v1;
            if (r_v1) r_rdata  <= lane_mask(mem_rddata, r_be1);
            if (r_v2) r_served <= r_served + 16'd1;
        end
    end

    assign readdata      = r_rdata;
    assign readdatavalid = r_v2;
    assign served_count  = r_served;

endmodule
`default_nettype wire
